seq_signed_divider: RTL and testbench

Iterative signed integer divider. It is the inverse-operation companion to the combinational signed multiplier and uses the same sign-magnitude approach: operands are converted to magnitudes, the magnitudes are divided, and the signs are applied at the end. The division itself is restoring, one quotient bit per clock. The block sits beside the multiplier in the arithmetic library and talks to its client through a start/done handshake.

---
 rtl/seq_signed_divider.sv | 141 ++++++++++++++
 tb/tb_seq_signed_divider.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_divider.sv
// Iterative signed divider, W-bit two's complement operands.
// Signs are stripped on accept, the magnitudes go through a restoring
// divide that produces one quotient bit per clock, and the signs are
// applied again in a single fix-up cycle. Handshake: start / busy / done.
module seq_signed_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t        state_q;

    // dq_q starts as |dividend| and is shifted out MSB-first while the
    // quotient bits are shifted in at the LSB.
    logic [W-1:0]  dq_q;
    logic [W-1:0]  dv_q;
    // Partial remainder is always < |divisor| <= 2^(W-1), so W bits hold
    // it; the extra bit of the W+1-bit partial remainder only exists in
    // the shifted trial value below.
    logic [W-1:0]  rem_q;
    logic [CW-1:0] cnt_q;
    logic          negq_q;
    logic          negr_q;
    logic          zero_q;
    logic [W-1:0]  orig_q;

    logic          busy_q;
    logic          done_q;
    logic [W-1:0]  quot_q;
    logic [W-1:0]  remo_q;
    logic          dbz_q;

    logic [W-1:0]  dd_mag_d;
    logic [W-1:0]  dv_mag_d;
    logic [W:0]    shift_d;
    logic [W:0]    trial_d;
    logic [W-1:0]  fix_quot_d;
    logic [W-1:0]  fix_rem_d;

    // Operand magnitudes, one restoring step, and sign re-application.
    always_comb begin
        dd_mag_d   = dividend[W-1] ? (~dividend + 1'b1) : dividend;
        dv_mag_d   = divisor[W-1]  ? (~divisor  + 1'b1) : divisor;
        shift_d    = {rem_q, dq_q[W-1]};
        trial_d    = shift_d - {1'b0, dv_q};
        fix_quot_d = negq_q ? (~dq_q  + 1'b1) : dq_q;
        fix_rem_d  = negr_q ? (~rem_q + 1'b1) : rem_q;
    end

    // Control FSM and datapath registers, including the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dq_q    <= '0;
            dv_q    <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            zero_q  <= 1'b0;
            orig_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        dq_q    <= dd_mag_d;
                        dv_q    <= dv_mag_d;
                        rem_q   <= '0;
                        cnt_q   <= CW'(W);
                        negq_q  <= dividend[W-1] ^ divisor[W-1];
                        negr_q  <= dividend[W-1];
                        zero_q  <= (divisor == '0);
                        orig_q  <= dividend;
                        busy_q  <= 1'b1;
                        state_q <= (divisor == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    if (trial_d[W]) begin
                        rem_q <= shift_d[W-1:0];
                        dq_q  <= {dq_q[W-2:0], 1'b0};
                    end else begin
                        rem_q <= trial_d[W-1:0];
                        dq_q  <= {dq_q[W-2:0], 1'b1};
                    end
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (zero_q) begin
                        quot_q <= '1;
                        remo_q <= orig_q;
                        dbz_q  <= 1'b1;
                    end else begin
                        quot_q <= fix_quot_d;
                        remo_q <= fix_rem_d;
                        dbz_q  <= 1'b0;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider at W=8: stimulus pushes the
// expected result and completion cycle, a monitor pops on every done.
`timescale 1ns/1ps
module tb_seq_signed_divider;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int unsigned  dcyc;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;

    seq_signed_divider #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                exp_t        e;
                logic [W-1:0] inv;
                int          ar;
                int          ab;
                e = sb.pop_front();
                chk("quotient", 32'(quotient), 32'(e.q));
                chk("remainder", 32'(remainder), 32'(e.r));
                chk("div_by_zero", 32'(div_by_zero), 32'(e.z));
                chk("done_latency", cyc, e.dcyc);
                if (!e.z) begin
                    inv = quotient * e.b + remainder;
                    chk("invariant_qd_plus_r", 32'(inv), 32'(e.a));
                    ar = $signed(remainder);
                    ab = $signed(e.b);
                    if (ar < 0) ar = -ar;
                    if (ab < 0) ab = -ab;
                    chk("invariant_rem_lt_div", 32'(ar < ab), 32'd1);
                end
            end
        end
    end

    // Drive one request at the current negedge and record its expectation.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
        exp_t e;
        e.a = a; e.b = b; e.q = q; e.r = r; e.z = z;
        e.dcyc = cyc + 1 + ((b == '0) ? 1 : W + 1);
        sb.push_back(e);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Wait for done, checking busy on every cycle in between.
    task automatic wait_done(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            chk({nm, "_busy"}, 32'(busy), 32'd1);
            @(negedge clk);
        end
        if (!seen) begin
            chk({nm, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({nm, "_busy_at_done"}, 32'(busy), 32'd0);
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t vecs[10] = '{
        '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0},  //  100 /    7
        '{8'h9C,  8'd7,   8'hF2,  8'hFE,  1'b0},  // -100 /    7
        '{8'd100, 8'hF9,  8'hF2,  8'd2,   1'b0},  //  100 /   -7
        '{8'h9C,  8'hF9,  8'd14,  8'hFE,  1'b0},  // -100 /   -7
        '{8'd7,   8'h9C,  8'd0,   8'd7,   1'b0},  //    7 / -100
        '{8'h80,  8'hFF,  8'h80,  8'd0,   1'b0},  // -128 /   -1
        '{8'h80,  8'd1,   8'h80,  8'd0,   1'b0},  // -128 /    1
        '{8'h7F,  8'h80,  8'd0,   8'h7F,  1'b0},  //  127 / -128
        '{8'd5,   8'd0,   8'hFF,  8'd5,   1'b1},  //    5 /    0
        '{8'd13,  8'd4,   8'd3,   8'd1,   1'b0}   //   13 /    4
    };

    initial begin
        bit seen_done;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_quotient", 32'(quotient), 32'd0);
        chk("reset_remainder", 32'(remainder), 32'd0);
        chk("reset_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors, including sign combinations and edge operands.
        foreach (vecs[i]) begin
            @(negedge clk);
            issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);
            wait_done($sformatf("vec%0d", i));
        end

        // start while busy is ignored; the first result must stand and hold.
        @(negedge clk);
        issue(8'd20, 8'd3, 8'd6, 8'd2, 1'b0);
        repeat (3) @(negedge clk);
        dividend = 8'h55;
        divisor  = 8'h02;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done("ignored_start");
        repeat (3) @(negedge clk);
        chk("hold_quotient", 32'(quotient), 32'd6);
        chk("hold_remainder", 32'(remainder), 32'd2);

        // Back-to-back: second request issued during the done cycle.
        @(negedge clk);
        issue(8'hE7, 8'd4, 8'hFA, 8'hFF, 1'b0);   // -25 / 4 = -6 r -1
        wait_done("b2b_first");
        issue(8'd50, 8'hF8, 8'hFA, 8'd2, 1'b0);   // 50 / -8 = -6 r 2
        wait_done("b2b_second");

        // Reset part way through CALC aborts the operation.
        @(negedge clk);
        issue(8'd77, 8'd5, 8'd15, 8'd2, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_quotient", 32'(quotient), 32'd0);
        chk("abort_remainder", 32'(remainder), 32'd0);
        chk("abort_dbz", 32'(div_by_zero), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        @(negedge clk);
        issue(8'd77, 8'd5, 8'd15, 8'd2, 1'b0);
        wait_done("after_abort");

        // Random operands against a truncating-division reference.
        for (int n = 0; n < 1500; n++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [W-1:0] q;
            logic [W-1:0] r;
            logic         z;
            int           sa;
            int           sbv;
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 31) == 0) b = '0;
            sa  = $signed(a);
            sbv = $signed(b);
            if (sbv == 0) begin
                q = '1;
                r = a;
                z = 1'b1;
            end else begin
                q = W'(sa / sbv);
                r = W'(sa % sbv);
                z = 1'b0;
            end
            @(negedge clk);
            issue(a, b, q, r, z);
            wait_done("rand");
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
